// File: rtl/wb_port_ctrl_pkg.sv
// Shared widths and the buffered write-result payload for the writeback port.
package wb_port_ctrl_pkg;

   localparam int unsigned ASIZE         = 5;
   localparam int unsigned DSIZE         = 32;
   localparam int unsigned NREG          = 32;
   localparam int unsigned WB_FIFO_DEPTH = 2;

   // One pending register-file write: destination and value.
   typedef struct packed {
      logic [ASIZE-1:0] waddr;
      logic [DSIZE-1:0] wdata;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry synchronous FIFO holding ALU results awaiting the write port.
module wb_fifo2
   import wb_port_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int unsigned CW = $clog2(WB_FIFO_DEPTH + 1);

   wb_entry_t       mem [WB_FIFO_DEPTH];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(WB_FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy tracking; 1-bit pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_port_ctrl.sv
// Writeback write-port initiator: arbitrates memory and buffered ALU results
// onto the register-file write port and tracks per-register pending writes.
module wb_port_ctrl
   import wb_port_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_valid,
   input  logic [ASIZE-1:0] iss_waddr,
   input  logic [ASIZE-1:0] chk_addr1,
   input  logic [ASIZE-1:0] chk_addr2,
   output logic             stall,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [ASIZE-1:0] alu_waddr,
   input  logic [DSIZE-1:0] alu_wdata,
   input  logic             mem_valid,
   input  logic [ASIZE-1:0] mem_waddr,
   input  logic [DSIZE-1:0] mem_wdata,
   output logic             wen,
   output logic [ASIZE-1:0] waddr,
   output logic [DSIZE-1:0] wdata,
   output logic             err_orphan
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_set;
   logic [NREG-1:0] busy_clr;
   wb_entry_t       alu_entry;
   wb_entry_t       head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic            hz1;
   logic            hz2;
   logic            iss_hz;
   logic            iss_ok;

   assign alu_entry = '{waddr: alu_waddr, wdata: alu_wdata};
   assign alu_ready = ~fifo_full;
   assign fifo_pop  = ~mem_valid & ~fifo_empty;

   wb_fifo2 u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (alu_valid & alu_ready),
      .pop   (fifo_pop),
      .din   (alu_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Hazard detection; the register being written this cycle is forwarded by the RF.
   always_comb begin
      hz1    = busy[chk_addr1] & ~(wen & (waddr == chk_addr1));
      hz2    = busy[chk_addr2] & ~(wen & (waddr == chk_addr2));
      iss_hz = iss_valid & busy[iss_waddr] & ~(wen & (waddr == iss_waddr));
      stall  = hz1 | hz2 | iss_hz;
      iss_ok = iss_valid & ~stall;
   end

   // Scoreboard masks; set is applied after clear so a same-edge reissue wins.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (iss_ok) busy_set = NREG'(1) << iss_waddr;
      if (wen)    busy_clr = NREG'(1) << waddr;
   end

   // Busy scoreboard and sticky orphan-retire flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= '0;
         err_orphan <= 1'b0;
      end else begin
         busy <= (busy & ~busy_clr) | busy_set;
         if (wen && !busy[waddr]) err_orphan <= 1'b1;
      end
   end

   // Write-port arbitration: memory first, then FIFO head; address/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen   <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else if (mem_valid) begin
         wen   <= 1'b1;
         waddr <= mem_waddr;
         wdata <= mem_wdata;
      end else if (fifo_pop) begin
         wen   <= 1'b1;
         waddr <= head.waddr;
         wdata <= head.wdata;
      end else begin
         wen   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_ctrl.sv
// Bench for wb_port_ctrl: directed vector table, reset sequence, and random
// traffic against a queue-based reference model.
module tb_wb_port_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_waddr;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        stall;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_waddr;
   logic [31:0] alu_wdata;
   logic        mem_valid;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        err_orphan;

   int n_cmp = 0;
   int n_err = 0;

   wb_port_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (iss_valid),
      .iss_waddr  (iss_waddr),
      .chk_addr1  (chk_addr1),
      .chk_addr2  (chk_addr2),
      .stall      (stall),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_waddr  (alu_waddr),
      .alu_wdata  (alu_wdata),
      .mem_valid  (mem_valid),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .wen        (wen),
      .waddr      (waddr),
      .wdata      (wdata),
      .err_orphan (err_orphan)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        iv;
      logic [4:0]  ia, c1, c2;
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        e_stall, e_rdy, e_wen;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   // Reference model state
   ent_t        m_q[$];
   bit          m_busy[32];
   logic        m_wen;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic        m_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic iv, input logic [4:0] ia, input logic [4:0] c1,
                      input logic [4:0] c2, input logic av, input logic [4:0] aa,
                      input logic [31:0] ad, input logic mv, input logic [4:0] ma,
                      input logic [31:0] md, input logic s, input logic r,
                      input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic e);
      vec_t v;
      v.iv = iv; v.ia = ia; v.c1 = c1; v.c2 = c2;
      v.av = av; v.aa = aa; v.ad = ad;
      v.mv = mv; v.ma = ma; v.md = md;
      v.e_stall = s; v.e_rdy = r; v.e_wen = w; v.e_wa = wa; v.e_wd = wd; v.e_err = e;
      tbl.push_back(v);
   endtask

   task automatic idle();
      iss_valid = 1'b0; iss_waddr = '0; chk_addr1 = '0; chk_addr2 = '0;
      alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
      mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;
   endtask

   task automatic apply(input vec_t v);
      iss_valid = v.iv; iss_waddr = v.ia; chk_addr1 = v.c1; chk_addr2 = v.c2;
      alu_valid = v.av; alu_waddr = v.aa; alu_wdata = v.ad;
      mem_valid = v.mv; mem_waddr = v.ma; mem_wdata = v.md;
   endtask

   task automatic m_reset();
      m_q.delete();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
   endtask

   function automatic bit m_hz(input logic [4:0] a);
      return m_busy[a] && !(m_wen && m_waddr == a);
   endfunction

   function automatic bit m_stall();
      return m_hz(chk_addr1) || m_hz(chk_addr2) || (iss_valid && m_hz(iss_waddr));
   endfunction

   // Advance the model across one clock edge using the current inputs.
   task automatic m_step();
      bit   st;
      bit   rdy;
      ent_t e;
      st  = m_stall();
      rdy = (m_q.size() < 2);
      if (m_wen) begin
         if (!m_busy[m_waddr]) m_err = 1'b1;
         m_busy[m_waddr] = 1'b0;
      end
      if (iss_valid && !st) m_busy[iss_waddr] = 1'b1;
      if (mem_valid) begin
         m_wen = 1'b1; m_waddr = mem_waddr; m_wdata = mem_wdata;
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         m_wen = 1'b1; m_waddr = e.a; m_wdata = e.d;
      end else begin
         m_wen = 1'b0;
      end
      if (alu_valid && rdy) begin
         e.a = alu_waddr; e.d = alu_wdata;
         m_q.push_back(e);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;

      // iv ia c1 c2 | av aa ad | mv ma md | stall rdy wen waddr wdata err
      add(1,4,0,0, 0,0,0,            0,0,0,    0,1,0,0,0,0);
      add(0,0,4,0, 1,4,32'hDEADBEEF, 0,0,0,    1,1,0,0,0,0);
      add(0,0,4,0, 0,0,0,            0,0,0,    1,1,0,0,0,0);
      add(0,0,4,0, 0,0,0,            0,0,0,    0,1,1,4,32'hDEADBEEF,0);
      add(0,0,4,0, 0,0,0,            0,0,0,    0,1,0,4,32'hDEADBEEF,0);
      add(1,5,0,0, 0,0,0,            0,0,0,    0,1,0,4,32'hDEADBEEF,0);
      add(1,6,0,0, 0,0,0,            0,0,0,    0,1,0,4,32'hDEADBEEF,0);
      add(1,8,0,0, 0,0,0,            0,0,0,    0,1,0,4,32'hDEADBEEF,0);
      add(1,10,0,0, 1,5,7,           0,0,0,    0,1,0,4,32'hDEADBEEF,0);
      add(1,11,0,0, 1,10,32'hA,      1,6,9,    0,1,0,4,32'hDEADBEEF,0);
      add(0,0,0,0, 1,11,32'hB,       1,8,32'h88, 0,0,1,6,9,0);
      add(0,0,0,0, 1,11,32'hB,       0,0,0,    0,0,1,8,32'h88,0);
      add(0,0,0,0, 1,11,32'hB,       0,0,0,    0,1,1,5,7,0);
      add(0,0,0,0, 0,0,0,            0,0,0,    0,1,1,10,32'hA,0);
      add(0,0,0,0, 0,0,0,            0,0,0,    0,1,1,11,32'hB,0);
      add(0,0,0,0, 0,0,0,            0,0,0,    0,1,0,11,32'hB,0);
      add(1,7,0,0, 0,0,0,            0,0,0,    0,1,0,11,32'hB,0);
      add(1,7,0,0, 1,7,32'h77,       0,0,0,    1,1,0,11,32'hB,0);
      add(1,7,0,0, 0,0,0,            0,0,0,    1,1,0,11,32'hB,0);
      add(1,7,0,0, 0,0,0,            0,0,0,    0,1,1,7,32'h77,0);
      add(0,0,7,0, 0,0,0,            0,0,0,    1,1,0,7,32'h77,0);
      add(0,0,7,0, 0,0,0,            1,7,32'h70, 1,1,0,7,32'h77,0);
      add(0,0,7,0, 0,0,0,            0,0,0,    0,1,1,7,32'h70,0);
      add(0,0,7,0, 0,0,0,            0,0,0,    0,1,0,7,32'h70,0);
      add(0,0,0,0, 0,0,0,            1,9,32'h99, 0,1,0,7,32'h70,0);
      add(0,0,0,0, 0,0,0,            0,0,0,    0,1,1,9,32'h99,0);
      add(0,0,0,0, 0,0,0,            0,0,0,    0,1,0,9,32'h99,1);
      add(0,0,0,0, 0,0,0,            0,0,0,    0,1,0,9,32'h99,1);

      foreach (tbl[i]) begin
         apply(tbl[i]);
         #1;
         chk($sformatf("vec%0d stall", i),     32'(stall),      32'(tbl[i].e_stall));
         chk($sformatf("vec%0d alu_ready", i), 32'(alu_ready),  32'(tbl[i].e_rdy));
         chk($sformatf("vec%0d wen", i),       32'(wen),        32'(tbl[i].e_wen));
         chk($sformatf("vec%0d waddr", i),     32'(waddr),      32'(tbl[i].e_wa));
         chk($sformatf("vec%0d wdata", i),     wdata,           tbl[i].e_wd);
         chk($sformatf("vec%0d err_orphan", i), 32'(err_orphan), 32'(tbl[i].e_err));
         @(posedge clk); #1;
      end

      // Reset mid-operation with a full FIFO and busy[3] pending.
      idle(); iss_valid = 1'b1; iss_waddr = 5'd3; mem_valid = 1'b1; mem_waddr = 5'd20; mem_wdata = 32'h1;
      @(posedge clk); #1;
      idle(); alu_valid = 1'b1; alu_waddr = 5'd12; alu_wdata = 32'hC;
      mem_valid = 1'b1; mem_waddr = 5'd21; mem_wdata = 32'h2;
      @(posedge clk); #1;
      idle(); alu_valid = 1'b1; alu_waddr = 5'd13; alu_wdata = 32'hD;
      mem_valid = 1'b1; mem_waddr = 5'd22; mem_wdata = 32'h3;
      @(posedge clk); #1;
      idle(); chk_addr1 = 5'd3; chk_addr2 = 5'd12;
      #1;
      chk("pre_rst alu_ready", 32'(alu_ready), 32'd0);
      chk("pre_rst wen",       32'(wen),       32'd1);
      chk("pre_rst stall",     32'(stall),     32'd1);
      #1 rst = 1'b1;
      #1;
      chk("in_rst wen",        32'(wen),        32'd0);
      chk("in_rst waddr",      32'(waddr),      32'd0);
      chk("in_rst wdata",      wdata,           32'd0);
      chk("in_rst err_orphan", 32'(err_orphan), 32'd0);
      chk("in_rst alu_ready",  32'(alu_ready),  32'd1);
      chk("in_rst stall",      32'(stall),      32'd0);
      #2 rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst%0d wen", k),       32'(wen),       32'd0);
         chk($sformatf("post_rst%0d alu_ready", k), 32'(alu_ready), 32'd1);
         chk($sformatf("post_rst%0d stall", k),     32'(stall),     32'd0);
      end

      // Random traffic against the reference model, with periodic resets.
      idle();
      @(posedge clk); #2 rst = 1'b1;
      #2 rst = 1'b0;
      m_reset();
      @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 499) begin
            idle();
            #1 rst = 1'b1;
            #2 rst = 1'b0;
            m_reset();
            @(posedge clk); #1;
         end else begin
            iss_valid = 1'($urandom_range(0, 1));
            iss_waddr = 5'($urandom_range(0, 7));
            chk_addr1 = 5'($urandom_range(0, 7));
            chk_addr2 = 5'($urandom_range(0, 7));
            alu_valid = 1'($urandom_range(0, 1));
            alu_waddr = 5'($urandom_range(0, 7));
            alu_wdata = $urandom;
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_waddr = 5'($urandom_range(0, 7));
            mem_wdata = $urandom;
            #1;
            chk("rnd stall",      32'(stall),      32'(m_stall()));
            chk("rnd alu_ready",  32'(alu_ready),  32'(m_q.size() < 2));
            chk("rnd wen",        32'(wen),        32'(m_wen));
            chk("rnd waddr",      32'(waddr),      32'(m_waddr));
            chk("rnd wdata",      wdata,           m_wdata);
            chk("rnd err_orphan", 32'(err_orphan), 32'(m_err));
            m_step();
            @(posedge clk); #1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
